// File: rtl/bp_me_burst_lite_pkg.sv
// Shared definitions for the burst <-> lite bridge: header layout, message
// type encodings, default payload masks, FSM state types and the beat-count
// helper used by both directions.
package bp_me_burst_lite_pkg;

    // Header field offsets (64-bit header)
    localparam int HDR_MSG_LSB     = 0;
    localparam int HDR_MSG_W       = 4;
    localparam int HDR_SIZE_LSB    = 4;
    localparam int HDR_SIZE_W      = 3;
    localparam int HDR_ADDR_LSB    = 8;
    localparam int HDR_ADDR_W      = 40;
    localparam int HDR_PAYLOAD_LSB = 48;
    localparam int HDR_PAYLOAD_W   = 16;

    typedef struct packed {
        logic [HDR_PAYLOAD_W-1:0] payload;
        logic [HDR_ADDR_W-1:0]    addr;
        logic                     rsvd;
        logic [HDR_SIZE_W-1:0]    size;
        logic [HDR_MSG_W-1:0]     msg_type;
    } bp_me_hdr_s;

    typedef enum logic [3:0] {
        MSG_RD    = 4'd0,
        MSG_WR    = 4'd1,
        MSG_UC_RD = 4'd2,
        MSG_UC_WR = 4'd3
    } bp_msg_type_e;

    // Writes carry data on the command side, reads carry data on the response side
    localparam logic [15:0] CMD_PAYLOAD_MASK_DEF  = 16'h000A;
    localparam logic [15:0] RESP_PAYLOAD_MASK_DEF = 16'h0005;

    typedef enum logic [1:0] {
        CMD_IDLE    = 2'd0,
        CMD_COLLECT = 2'd1,
        CMD_SEND    = 2'd2
    } cmd_state_e;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_HDR  = 2'd1,
        RESP_DATA = 2'd2
    } resp_state_e;

    // Beats needed for a message of (8 << size) bits, at least one
    function automatic int unsigned raw_beats(input logic [HDR_SIZE_W-1:0] size,
                                              input int unsigned narrow_w);
        int unsigned n;
        n = (32'd8 << size) / narrow_w;
        if (n == 0) n = 1;
        return n;
    endfunction

    // Same, clipped to what one wide message can hold
    function automatic int unsigned beat_count(input logic [HDR_SIZE_W-1:0] size,
                                               input int unsigned narrow_w,
                                               input int unsigned wide_w);
        int unsigned n;
        n = raw_beats(size, narrow_w);
        if (n > wide_w / narrow_w) n = wide_w / narrow_w;
        return n;
    endfunction

endpackage

// File: rtl/bp_me_beat_counter.sv
// Beat counter for one bridge direction: loaded with the beat count of a
// message, steps once per data transfer, flags the final beat and reports the
// index of the beat currently being transferred.
module bp_me_beat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             blackparrot_clk,
    input  logic             blackparrot_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_n,
    input  logic             i_dec,
    output logic             o_last,
    output logic [CNT_W-1:0] o_idx
);

    logic [CNT_W-1:0] r_left;
    logic [CNT_W-1:0] r_idx;

    // Remaining-beat and beat-index registers; load wins over decrement
    always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
        if (!blackparrot_reset) begin
            r_left <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_left <= i_n;
            r_idx  <= '0;
        end else if (i_dec) begin
            r_left <= r_left - CNT_W'(1);
            r_idx  <= r_idx + CNT_W'(1);
        end
    end

    assign o_last = (r_left == CNT_W'(1));
    assign o_idx  = r_idx;

endmodule

// File: rtl/bp_me_burst_lite.sv
// The bridge top lives in bp_me_burst_lite_bridge.sv.
// This file carries the wide-data fill helper used by the command path:
// a beat is written into every wide slot whose index is congruent to the beat
// number modulo the beat count, so short messages come out replicated.
module bp_me_burst_lite_fill
    import bp_me_burst_lite_pkg::*;
#(
    parameter int NARROW_W = 64,
    parameter int WIDE_W   = 512,
    parameter int CNT_W    = 4
) (
    input  logic [WIDE_W-1:0]   i_wide,
    input  logic [NARROW_W-1:0] i_beat,
    input  logic [CNT_W-1:0]    i_idx,
    input  logic [CNT_W-1:0]    i_n,
    output logic [WIDE_W-1:0]   o_wide
);

    localparam int BEATS = WIDE_W / NARROW_W;

    // Overlay the incoming beat on each slot it owns
    always_comb begin
        o_wide = i_wide;
        for (int j = 0; j < BEATS; j++) begin
            if ((j % int'(i_n)) == int'(i_idx))
                o_wide[j*NARROW_W +: NARROW_W] = i_beat;
        end
    end

endmodule

// File: rtl/bp_me_burst_lite_bridge.sv
// Burst <-> lite bridge. The command path gathers a burst header plus data
// beats into one wide lite command; the response path splits a wide lite
// response into a burst header followed by data beats. The two paths share
// nothing but clock and reset.
// Optional: define BP_ME_BURST_LITE_ASSERT_EN to compile simulation checks
// for oversized messages and valids dropped before acceptance.
module bp_me_burst_lite_bridge
    import bp_me_burst_lite_pkg::*;
#(
    parameter int          HDR_W             = 64,
    parameter int          NARROW_W          = 64,
    parameter int          WIDE_W            = 512,
    parameter logic [15:0] CMD_PAYLOAD_MASK  = CMD_PAYLOAD_MASK_DEF,
    parameter logic [15:0] RESP_PAYLOAD_MASK = RESP_PAYLOAD_MASK_DEF
) (
    input  logic                    blackparrot_clk,
    input  logic                    blackparrot_reset,
    input  logic [HDR_W-1:0]        cmd_hdr_i,
    input  logic                    cmd_hdr_v_i,
    output logic                    cmd_hdr_ready_and_o,
    input  logic [NARROW_W-1:0]     cmd_data_i,
    input  logic                    cmd_data_v_i,
    output logic                    cmd_data_ready_and_o,
    output logic [HDR_W+WIDE_W-1:0] lite_cmd_o,
    output logic                    lite_cmd_v_o,
    input  logic                    lite_cmd_ready_and_i,
    input  logic [HDR_W+WIDE_W-1:0] lite_resp_i,
    input  logic                    lite_resp_v_i,
    output logic                    lite_resp_ready_and_o,
    output logic [HDR_W-1:0]        resp_hdr_o,
    output logic                    resp_hdr_v_o,
    input  logic                    resp_hdr_ready_and_i,
    output logic [NARROW_W-1:0]     resp_data_o,
    output logic                    resp_data_v_o,
    input  logic                    resp_data_ready_and_i
);

    localparam int BEATS = WIDE_W / NARROW_W;
    localparam int CNT_W = $clog2(BEATS + 1);

    // Ready outputs stay low until the first clock after reset release
    logic r_rst_done;

    // Reset-release flag
    always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
        if (!blackparrot_reset) r_rst_done <= 1'b0;
        else                    r_rst_done <= 1'b1;
    end

    // ---------------- command path: burst -> lite ----------------
    cmd_state_e        r_cmd_st, w_cmd_st_nxt;
    logic [HDR_W-1:0]  r_cmd_hdr;
    logic [WIDE_W-1:0] r_cmd_data;
    logic [WIDE_W-1:0] w_cmd_fill;
    logic              w_cmd_hdr_fire, w_cmd_data_fire, w_cmd_last;
    logic [CNT_W-1:0]  w_cmd_n_new, w_cmd_n_cur, w_cmd_idx;

    assign w_cmd_hdr_fire  = cmd_hdr_v_i  & cmd_hdr_ready_and_o;
    assign w_cmd_data_fire = cmd_data_v_i & cmd_data_ready_and_o;
    assign w_cmd_n_new = CNT_W'(beat_count(cmd_hdr_i[HDR_SIZE_LSB +: HDR_SIZE_W], NARROW_W, WIDE_W));
    assign w_cmd_n_cur = CNT_W'(beat_count(r_cmd_hdr[HDR_SIZE_LSB +: HDR_SIZE_W], NARROW_W, WIDE_W));

    bp_me_beat_counter #(.CNT_W(CNT_W)) u_cmd_cnt (
        .blackparrot_clk   (blackparrot_clk),
        .blackparrot_reset (blackparrot_reset),
        .i_load            (w_cmd_hdr_fire),
        .i_n               (w_cmd_n_new),
        .i_dec             (w_cmd_data_fire),
        .o_last            (w_cmd_last),
        .o_idx             (w_cmd_idx)
    );

    bp_me_burst_lite_fill #(.NARROW_W(NARROW_W), .WIDE_W(WIDE_W), .CNT_W(CNT_W)) u_cmd_fill (
        .i_wide (r_cmd_data),
        .i_beat (cmd_data_i),
        .i_idx  (w_cmd_idx),
        .i_n    (w_cmd_n_cur),
        .o_wide (w_cmd_fill)
    );

    // Command state register
    always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
        if (!blackparrot_reset) r_cmd_st <= CMD_IDLE;
        else                    r_cmd_st <= w_cmd_st_nxt;
    end

    // Command next state and handshake outputs
    always_comb begin
        w_cmd_st_nxt         = r_cmd_st;
        cmd_hdr_ready_and_o  = 1'b0;
        cmd_data_ready_and_o = 1'b0;
        lite_cmd_v_o         = 1'b0;
        case (r_cmd_st)
            CMD_IDLE: begin
                cmd_hdr_ready_and_o = r_rst_done;
                if (w_cmd_hdr_fire)
                    w_cmd_st_nxt = CMD_PAYLOAD_MASK[cmd_hdr_i[HDR_MSG_LSB +: HDR_MSG_W]]
                                 ? CMD_COLLECT : CMD_SEND;
            end
            CMD_COLLECT: begin
                cmd_data_ready_and_o = 1'b1;
                if (w_cmd_data_fire && w_cmd_last) w_cmd_st_nxt = CMD_SEND;
            end
            CMD_SEND: begin
                lite_cmd_v_o = 1'b1;
                if (lite_cmd_ready_and_i) w_cmd_st_nxt = CMD_IDLE;
            end
            default: w_cmd_st_nxt = CMD_IDLE;
        endcase
    end

    // Header capture and wide data assembly
    always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
        if (!blackparrot_reset) begin
            r_cmd_hdr  <= '0;
            r_cmd_data <= '0;
        end else begin
            if (w_cmd_hdr_fire)  r_cmd_hdr  <= cmd_hdr_i;
            if (w_cmd_data_fire) r_cmd_data <= w_cmd_fill;
        end
    end

    assign lite_cmd_o = {r_cmd_data, r_cmd_hdr};

    // ---------------- response path: lite -> burst ----------------
    resp_state_e       r_resp_st, w_resp_st_nxt;
    logic [HDR_W-1:0]  r_resp_hdr;
    logic [WIDE_W-1:0] r_resp_data;
    logic              w_resp_fire, w_resp_data_fire, w_resp_last;
    logic [CNT_W-1:0]  w_resp_n_new, w_resp_idx;

    assign w_resp_fire      = lite_resp_v_i & lite_resp_ready_and_o;
    assign w_resp_data_fire = resp_data_v_o & resp_data_ready_and_i;
    assign w_resp_n_new = CNT_W'(beat_count(lite_resp_i[HDR_SIZE_LSB +: HDR_SIZE_W], NARROW_W, WIDE_W));

    bp_me_beat_counter #(.CNT_W(CNT_W)) u_resp_cnt (
        .blackparrot_clk   (blackparrot_clk),
        .blackparrot_reset (blackparrot_reset),
        .i_load            (w_resp_fire),
        .i_n               (w_resp_n_new),
        .i_dec             (w_resp_data_fire),
        .o_last            (w_resp_last),
        .o_idx             (w_resp_idx)
    );

    // Response state register
    always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
        if (!blackparrot_reset) r_resp_st <= RESP_IDLE;
        else                    r_resp_st <= w_resp_st_nxt;
    end

    // Response next state and handshake outputs
    always_comb begin
        w_resp_st_nxt         = r_resp_st;
        lite_resp_ready_and_o = 1'b0;
        resp_hdr_v_o          = 1'b0;
        resp_data_v_o         = 1'b0;
        case (r_resp_st)
            RESP_IDLE: begin
                lite_resp_ready_and_o = r_rst_done;
                if (w_resp_fire) w_resp_st_nxt = RESP_HDR;
            end
            RESP_HDR: begin
                resp_hdr_v_o = 1'b1;
                if (resp_hdr_ready_and_i)
                    w_resp_st_nxt = RESP_PAYLOAD_MASK[r_resp_hdr[HDR_MSG_LSB +: HDR_MSG_W]]
                                  ? RESP_DATA : RESP_IDLE;
            end
            RESP_DATA: begin
                resp_data_v_o = 1'b1;
                if (resp_data_ready_and_i && w_resp_last) w_resp_st_nxt = RESP_IDLE;
            end
            default: w_resp_st_nxt = RESP_IDLE;
        endcase
    end

    // Whole lite response captured in one shot
    always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
        if (!blackparrot_reset) begin
            r_resp_hdr  <= '0;
            r_resp_data <= '0;
        end else if (w_resp_fire) begin
            r_resp_hdr  <= lite_resp_i[HDR_W-1:0];
            r_resp_data <= lite_resp_i[HDR_W +: WIDE_W];
        end
    end

    assign resp_hdr_o  = r_resp_hdr;
    assign resp_data_o = r_resp_data[int'(w_resp_idx)*NARROW_W +: NARROW_W];

`ifdef BP_ME_BURST_LITE_ASSERT_EN
    a_cmd_size: assert property (@(posedge blackparrot_clk) disable iff (!blackparrot_reset)
        w_cmd_hdr_fire |-> (raw_beats(cmd_hdr_i[HDR_SIZE_LSB +: HDR_SIZE_W], NARROW_W) <= BEATS))
        else $error("cmd size exceeds wide width");
    a_resp_size: assert property (@(posedge blackparrot_clk) disable iff (!blackparrot_reset)
        w_resp_fire |-> (raw_beats(lite_resp_i[HDR_SIZE_LSB +: HDR_SIZE_W], NARROW_W) <= BEATS))
        else $error("resp size exceeds wide width");
    a_lite_cmd_hold: assert property (@(posedge blackparrot_clk) disable iff (!blackparrot_reset)
        (lite_cmd_v_o && !lite_cmd_ready_and_i) |=> lite_cmd_v_o)
        else $error("lite_cmd_v_o dropped before accept");
    a_resp_hdr_hold: assert property (@(posedge blackparrot_clk) disable iff (!blackparrot_reset)
        (resp_hdr_v_o && !resp_hdr_ready_and_i) |=> resp_hdr_v_o)
        else $error("resp_hdr_v_o dropped before accept");
    a_resp_data_hold: assert property (@(posedge blackparrot_clk) disable iff (!blackparrot_reset)
        (resp_data_v_o && !resp_data_ready_and_i) |=> resp_data_v_o)
        else $error("resp_data_v_o dropped before accept");
`endif

endmodule

// File: tb/tb_bp_me_burst_lite_bridge.sv
// Bench for bp_me_burst_lite_bridge: directed cases followed by concurrent
// randomized command and response traffic, checked against a transaction
// model (beat counts, replication, header/data ordering) kept in queues.
module tb_bp_me_burst_lite_bridge;

    localparam int HW = 64;
    localparam int NW = 64;
    localparam int WW = 512;
    localparam int TO = 1000;

    logic blackparrot_clk = 1'b0;
    logic blackparrot_reset = 1'b0;
    always #5 blackparrot_clk = ~blackparrot_clk;

    logic [HW-1:0]    cmd_hdr_i = '0;
    logic             cmd_hdr_v_i = 1'b0, cmd_hdr_ready_and_o;
    logic [NW-1:0]    cmd_data_i = '0;
    logic             cmd_data_v_i = 1'b0, cmd_data_ready_and_o;
    logic [HW+WW-1:0] lite_cmd_o;
    logic             lite_cmd_v_o, lite_cmd_ready_and_i = 1'b0;
    logic [HW+WW-1:0] lite_resp_i = '0;
    logic             lite_resp_v_i = 1'b0, lite_resp_ready_and_o;
    logic [HW-1:0]    resp_hdr_o;
    logic             resp_hdr_v_o, resp_hdr_ready_and_i = 1'b0;
    logic [NW-1:0]    resp_data_o;
    logic             resp_data_v_o, resp_data_ready_and_i = 1'b0;

    bp_me_burst_lite_bridge #(.HDR_W(HW), .NARROW_W(NW), .WIDE_W(WW)) dut (
        .blackparrot_clk       (blackparrot_clk),
        .blackparrot_reset     (blackparrot_reset),
        .cmd_hdr_i             (cmd_hdr_i),
        .cmd_hdr_v_i           (cmd_hdr_v_i),
        .cmd_hdr_ready_and_o   (cmd_hdr_ready_and_o),
        .cmd_data_i            (cmd_data_i),
        .cmd_data_v_i          (cmd_data_v_i),
        .cmd_data_ready_and_o  (cmd_data_ready_and_o),
        .lite_cmd_o            (lite_cmd_o),
        .lite_cmd_v_o          (lite_cmd_v_o),
        .lite_cmd_ready_and_i  (lite_cmd_ready_and_i),
        .lite_resp_i           (lite_resp_i),
        .lite_resp_v_i         (lite_resp_v_i),
        .lite_resp_ready_and_o (lite_resp_ready_and_o),
        .resp_hdr_o            (resp_hdr_o),
        .resp_hdr_v_o          (resp_hdr_v_o),
        .resp_hdr_ready_and_i  (resp_hdr_ready_and_i),
        .resp_data_o           (resp_data_o),
        .resp_data_v_o         (resp_data_v_o),
        .resp_data_ready_and_i (resp_data_ready_and_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [HW+WW-1:0] got, input logic [HW+WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [HW-1:0] hdr; logic [WW-1:0] data; bit has_data; } lc_t;
    typedef struct { bit is_hdr; logic [HW-1:0] val; } rs_t;
    lc_t lc_q[$];
    rs_t rs_q[$];

    // Ready behaviour knobs
    bit lc_hold_mode = 1'b1;
    bit lc_hold = 1'b1;
    bit rh_rand = 1'b0;
    bit rd_tog  = 1'b0;

    // Message length in beats: bytes = 8 << size bits... i.e. 2^size bytes
    function automatic int nbeats(input logic [2:0] size);
        int bytes = 1 << size;
        int n = (bytes * 8) / NW;
        if (n < 1) n = 1;
        if (n > WW / NW) n = WW / NW;
        return n;
    endfunction

    function automatic logic [WW-1:0] rnd_wide();
        logic [WW-1:0] r;
        for (int i = 0; i < WW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [HW-1:0] mk_hdr(input int mt, input int sz);
        logic [HW-1:0] h;
        h = {$urandom, $urandom};
        h[3:0] = 4'(mt);
        h[6:4] = 3'(sz);
        return h;
    endfunction

    // Output-side monitor/sink: drives readies, scores every transfer
    always @(negedge blackparrot_clk) begin
        lc_t e;
        rs_t r;
        lite_cmd_ready_and_i  = lc_hold_mode ? lc_hold : 1'($urandom_range(0, 1));
        resp_hdr_ready_and_i  = rh_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        resp_data_ready_and_i = rd_tog ? ~resp_data_ready_and_i : 1'($urandom_range(0, 1));
        if (blackparrot_reset) begin
            if (resp_hdr_v_o && resp_data_v_o) chk("resp_hdr_data_overlap", resp_data_v_o, 1'b0);
            if (lite_cmd_v_o && lite_cmd_ready_and_i) begin
                if (lc_q.size() == 0) chk("lite_cmd_unexpected", lite_cmd_v_o, 1'b0);
                else begin
                    e = lc_q.pop_front();
                    chk("lite_cmd_hdr", lite_cmd_o[HW-1:0], e.hdr);
                    if (e.has_data) chk("lite_cmd_data", lite_cmd_o[HW +: WW], e.data);
                end
            end
            if (resp_hdr_v_o && resp_hdr_ready_and_i) begin
                if (rs_q.size() == 0 || !rs_q[0].is_hdr) chk("resp_hdr_unexpected", resp_hdr_v_o, 1'b0);
                else begin
                    r = rs_q.pop_front();
                    chk("resp_hdr", resp_hdr_o, r.val);
                end
            end
            if (resp_data_v_o && resp_data_ready_and_i) begin
                if (rs_q.size() == 0 || rs_q[0].is_hdr) chk("resp_data_unexpected", resp_data_v_o, 1'b0);
                else begin
                    r = rs_q.pop_front();
                    chk("resp_data", resp_data_o, r.val);
                end
            end
        end
    end

    task automatic wait_rdy(input string tag, ref logic rdy);
        int t = 0;
        while (!rdy && t < TO) begin @(negedge blackparrot_clk); t++; end
        if (t >= TO) chk(tag, rdy, 1'b1);
    endtask

    // Burst command: header, then beats if the type carries data
    task automatic send_cmd(input logic [HW-1:0] hdr, input logic [WW-1:0] beats, input bit bubbles);
        lc_t e;
        int n = nbeats(hdr[6:4]);
        e.hdr = hdr;
        e.has_data = (hdr[3:0] == 4'd1) || (hdr[3:0] == 4'd3);
        for (int j = 0; j < WW / NW; j++) e.data[j*NW +: NW] = beats[(j % n)*NW +: NW];
        lc_q.push_back(e);
        @(negedge blackparrot_clk);
        cmd_hdr_i = hdr;
        cmd_hdr_v_i = 1'b1;
        wait_rdy("cmd_hdr_timeout", cmd_hdr_ready_and_o);
        @(negedge blackparrot_clk);
        cmd_hdr_v_i = 1'b0;
        if (e.has_data) begin
            for (int k = 0; k < n; k++) begin
                if (bubbles && $urandom_range(0, 2) == 0) begin
                    cmd_data_v_i = 1'b0;
                    @(negedge blackparrot_clk);
                end
                cmd_data_i = beats[k*NW +: NW];
                cmd_data_v_i = 1'b1;
                wait_rdy("cmd_data_timeout", cmd_data_ready_and_o);
                @(negedge blackparrot_clk);
            end
            cmd_data_v_i = 1'b0;
        end
        chk("cmd_latency", lite_cmd_v_o, 1'b1);
    endtask

    // Lite response: expect header then beats if the type carries data
    task automatic send_resp(input logic [HW-1:0] hdr, input logic [WW-1:0] data);
        rs_t r;
        int n = nbeats(hdr[6:4]);
        r.is_hdr = 1'b1; r.val = hdr;
        rs_q.push_back(r);
        if ((hdr[3:0] == 4'd0) || (hdr[3:0] == 4'd2))
            for (int k = 0; k < n; k++) begin
                r.is_hdr = 1'b0; r.val = data[k*NW +: NW];
                rs_q.push_back(r);
            end
        @(negedge blackparrot_clk);
        lite_resp_i = {data, hdr};
        lite_resp_v_i = 1'b1;
        wait_rdy("lite_resp_timeout", lite_resp_ready_and_o);
        @(negedge blackparrot_clk);
        lite_resp_v_i = 1'b0;
        chk("resp_latency", resp_hdr_v_o, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while ((lc_q.size() != 0 || rs_q.size() != 0) && t < 4 * TO) begin
            @(negedge blackparrot_clk); t++;
        end
        chk("drain_lite_cmd", lc_q.size(), 0);
        chk("drain_resp", rs_q.size(), 0);
        repeat (2) @(negedge blackparrot_clk);
    endtask

    initial begin
        logic [WW-1:0] b;
        lc_t e;

        // Reset state
        repeat (3) @(negedge blackparrot_clk);
        chk("rst_lite_cmd_v", lite_cmd_v_o, 1'b0);
        chk("rst_resp_hdr_v", resp_hdr_v_o, 1'b0);
        chk("rst_resp_data_v", resp_data_v_o, 1'b0);
        chk("rst_cmd_hdr_rdy", cmd_hdr_ready_and_o, 1'b0);
        chk("rst_lite_resp_rdy", lite_resp_ready_and_o, 1'b0);
        chk("rst_lite_cmd_data", lite_cmd_o, '0);
        chk("rst_resp_data", resp_data_o, '0);
        blackparrot_reset = 1'b1;
        #1;
        chk("rdy_before_edge", cmd_hdr_ready_and_o, 1'b0);
        @(negedge blackparrot_clk);
        chk("rdy_after_edge_cmd", cmd_hdr_ready_and_o, 1'b1);
        chk("rdy_after_edge_resp", lite_resp_ready_and_o, 1'b1);

        // Full-line write, beats 0..7
        for (int k = 0; k < 8; k++) b[k*NW +: NW] = 64'(k);
        send_cmd(mk_hdr(1, 6), b, 1'b0);
        drain();

        // Read command: no beats consumed in IDLE or SEND
        lc_hold = 1'b0;
        cmd_data_i = 64'hBAD0_BAD0_BAD0_BAD0;
        cmd_data_v_i = 1'b1;
        @(negedge blackparrot_clk);
        chk("rd_idle_no_data", cmd_data_ready_and_o, 1'b0);
        send_cmd(mk_hdr(0, 6), rnd_wide(), 1'b0);
        chk("rd_send_no_data", cmd_data_ready_and_o, 1'b0);
        lc_hold = 1'b1;
        drain();
        cmd_data_v_i = 1'b0;

        // Uncached 8-byte write replicated across the line
        b = '0;
        b[63:0] = 64'hDEADBEEF_CAFEF00D;
        send_cmd(mk_hdr(3, 3), b, 1'b0);
        drain();

        // Read response with toggling data ready
        rd_tog = 1'b1;
        for (int k = 0; k < 8; k++) b[k*NW +: NW] = 64'(8'h10 + k);
        send_resp(mk_hdr(0, 6), b);
        drain();
        rd_tog = 1'b0;

        // Backpressure on lite command for 20 cycles
        lc_hold = 1'b0;
        send_cmd(mk_hdr(1, 6), rnd_wide(), 1'b1);
        e = lc_q[0];
        for (int c = 0; c < 20; c++) begin
            @(negedge blackparrot_clk);
            chk("hold_v", lite_cmd_v_o, 1'b1);
            chk("hold_msg", lite_cmd_o[HW +: WW], e.data);
            chk("hold_hdr_rdy", cmd_hdr_ready_and_o, 1'b0);
        end
        lc_hold = 1'b1;
        drain();

        // Reset in the middle of a command collect
        @(negedge blackparrot_clk);
        cmd_hdr_i = mk_hdr(1, 6);
        cmd_hdr_v_i = 1'b1;
        wait_rdy("mid_hdr_timeout", cmd_hdr_ready_and_o);
        @(negedge blackparrot_clk);
        cmd_hdr_v_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmd_data_i = 64'(32'hA0 + k);
            cmd_data_v_i = 1'b1;
            wait_rdy("mid_data_timeout", cmd_data_ready_and_o);
            @(negedge blackparrot_clk);
        end
        cmd_data_v_i = 1'b0;
        blackparrot_reset = 1'b0;
        #1;
        chk("mid_rst_lite_cmd_v", lite_cmd_v_o, 1'b0);
        chk("mid_rst_resp_hdr_v", resp_hdr_v_o, 1'b0);
        chk("mid_rst_resp_data_v", resp_data_v_o, 1'b0);
        chk("mid_rst_cmd_data_rdy", cmd_data_ready_and_o, 1'b0);
        chk("mid_rst_cmd_hdr_rdy", cmd_hdr_ready_and_o, 1'b0);
        @(negedge blackparrot_clk);
        blackparrot_reset = 1'b1;
        @(negedge blackparrot_clk);
        for (int k = 0; k < 8; k++) b[k*NW +: NW] = {32'h5A5A_0000, 32'(k)};
        send_cmd(mk_hdr(1, 6), b, 1'b0);
        drain();

        // Concurrent random traffic on both paths
        lc_hold_mode = 1'b0;
        rh_rand = 1'b1;
        fork
            for (int i = 0; i < 25; i++)
                send_cmd(mk_hdr($urandom_range(0, 3), $urandom_range(0, 6)), rnd_wide(), 1'b1);
            for (int i = 0; i < 25; i++)
                send_resp(mk_hdr($urandom_range(0, 3), $urandom_range(0, 6)), rnd_wide());
        join
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bp_me_burst_lite_bridge.md
BP_ME_BURST_LITE_BRIDGE -- requirements
Module: bp_me_burst_lite_bridge

Interface
REQ-001 SHALL have parameter HDR_W, default 64: header width (msg_type[3:0], size[6:4], addr[47:8], payload[63:48]).
REQ-002 SHALL have parameter NARROW_W, default 64: burst data beat width.
REQ-003 SHALL have parameter WIDE_W, default 512: lite data width; multiple of NARROW_W.
REQ-004 SHALL have parameter CMD_PAYLOAD_MASK, default 16'h000A: bit i set means cmd msg_type i carries data.
REQ-005 SHALL have parameter RESP_PAYLOAD_MASK, default 16'h0005: bit i set means resp msg_type i carries data.
REQ-006 SHALL have ports as follows; reset is blackparrot_reset, asynchronous, active-low; clock is blackparrot_clk:
- blackparrot_clk  in  1  clock
- blackparrot_reset  in  1  async active-low reset
- cmd_hdr_i  in  HDR_W  burst cmd header; cmd_hdr_v_i in 1; cmd_hdr_ready_and_o out 1
- cmd_data_i  in  NARROW_W  burst cmd beat; cmd_data_v_i in 1; cmd_data_ready_and_o out 1
- lite_cmd_o  out  HDR_W+WIDE_W  {data, header}; lite_cmd_v_o out 1; lite_cmd_ready_and_i in 1
- lite_resp_i  in  HDR_W+WIDE_W  {data, header}; lite_resp_v_i in 1; lite_resp_ready_and_o out 1
- resp_hdr_o  out  HDR_W; resp_hdr_v_o out 1; resp_hdr_ready_and_i in 1
- resp_data_o  out  NARROW_W; resp_data_v_o out 1; resp_data_ready_and_i in 1

Function
REQ-007 All handshakes SHALL be valid/ready-and: transfer when both high in the same cycle; valid never depends combinationally on ready.
REQ-008 Beat count N SHALL be max(1, (8<<size)/NARROW_W), saturating at WIDE_W/NARROW_W.
REQ-009 Cmd path (burst->lite) SHALL have states IDLE, COLLECT, SEND.
REQ-010 IDLE: cmd_hdr_ready_and_o=1; on header accept latch header; go COLLECT if CMD_PAYLOAD_MASK[msg_type] else SEND.
REQ-011 COLLECT: cmd_data_ready_and_o=1; beat k SHALL be written to wide[k*NARROW_W +: NARROW_W]; after beat N-1 go SEND.
REQ-012 When N*NARROW_W < WIDE_W, the collected data SHALL be replicated to fill WIDE_W.
REQ-013 SEND: lite_cmd_v_o=1 with data unchanged until accepted; on accept go IDLE (back-to-back header accept next cycle).
REQ-014 Cmd data beats presented in IDLE or SEND SHALL NOT be accepted.
REQ-015 Resp path (lite->burst) SHALL have states IDLE, HDR, DATA.
REQ-016 IDLE: lite_resp_ready_and_o=1; on accept register the full message, go HDR.
REQ-017 HDR: resp_hdr_v_o=1; on accept go DATA if RESP_PAYLOAD_MASK[msg_type] else IDLE.
REQ-018 DATA: resp_data_o SHALL equal wide[k*NARROW_W +: NARROW_W] for beat k; after beat N-1 accepted go IDLE.
REQ-019 Header on resp_hdr_o SHALL be the lite header unmodified; data SHALL NOT be presented before header accept.
REQ-020 Cmd and resp paths SHALL be fully independent and concurrent.
REQ-021 Minimum latency: lite_cmd_v_o one cycle after last beat (or header for no-payload); resp_hdr_v_o one cycle after lite accept.

Reset
REQ-022 While blackparrot_reset=0: both FSMs IDLE; all *_v_o=0; cmd_hdr_ready_and_o and lite_resp_ready_and_o=0; data registers cleared to 0.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer; partial beats discarded.
REQ-024 Ready outputs SHALL rise the first cycle after reset deassertion.

Configuration
REQ-025 With BP_ME_BURST_LITE_ASSERT_EN defined, simulation assertions SHALL fire on: size yielding N > WIDE_W/NARROW_W, and any valid output dropping before accept.
REQ-026 Without BP_ME_BURST_LITE_ASSERT_EN, no assertion code SHALL be compiled; function identical.

Structure
REQ-027 Header typedef, field offsets, msg_type encodings (0 rd, 1 wr, 2 uc_rd, 3 uc_wr) and default masks SHALL live in package bp_me_burst_lite_pkg.
REQ-028 A beat-counter sub-module bp_me_beat_counter (load N, decrement on transfer, last flag) SHALL be instantiated once per path.

Verification
REQ-029 Cmd wr, size 6 (64 B), beats 0..7 = 0x0..0x7 -> one lite_cmd_o, data[64k+:64]=k, header unchanged.
REQ-030 Cmd rd, size 6 -> lite_cmd_v_o next cycle, no data beats consumed.
REQ-031 Cmd uc_wr, size 3, beat 0xDEADBEEF_CAFEF00D -> lite data = that value replicated 8x.
REQ-032 Lite resp rd, size 6, data beats 0x10..0x17 -> header then 8 beats 0x10..0x17 in order, resp_data_ready_and_i toggling every cycle.
REQ-033 lite_cmd_ready_and_i held 0 for 20 cycles -> lite_cmd_v_o and data stable; cmd_hdr_ready_and_o stays 0.
REQ-034 Reset pulsed after 3 of 8 cmd beats -> all valids 0; next full transaction correct.
